// File: rtl/wd_xbar_pkg.sv
// ============================================================================
// Module : wd_xbar_pkg
// Brief  : Shared widths and order-queue entry layout for the W-channel router.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wd_xbar_pkg;

   localparam int LEN_W         = 8;
   localparam int ENTRY_LEN_LSB = 0;
   localparam int ENTRY_SRC_LSB = LEN_W;

   // Port-ID width: ceil(log2(n)), never narrower than one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wd_xbar_router_if.sv
// ============================================================================
// Module : wd_xbar_router_if
// Brief  : AW-grant and W-channel signal bundle for wd_xbar_router.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wd_xbar_router_if
   import wd_xbar_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int NUM_DST = 2,
   parameter int DATA_W  = 32
);
   localparam int SRC_W  = id_width(NUM_SRC);
   localparam int DST_W  = id_width(NUM_DST);
   localparam int STRB_W = DATA_W / 8;

   logic                        aw_push;
   logic [SRC_W-1:0]            aw_src;
   logic [DST_W-1:0]            aw_dst;
   logic [LEN_W-1:0]            aw_len;
   logic                        aw_full;

   logic [NUM_SRC*DATA_W-1:0]   S_AXI_wdata;
   logic [NUM_SRC*STRB_W-1:0]   S_AXI_wstrb;
   logic [NUM_SRC-1:0]          S_AXI_wlast;
   logic [NUM_SRC-1:0]          S_AXI_wvalid;
   logic [NUM_SRC-1:0]          S_AXI_wready;

   logic [NUM_DST*DATA_W-1:0]   M_AXI_wdata;
   logic [NUM_DST*STRB_W-1:0]   M_AXI_wstrb;
   logic [NUM_DST-1:0]          M_AXI_wlast;
   logic [NUM_DST-1:0]          M_AXI_wvalid;
   logic [NUM_DST-1:0]          M_AXI_wready;

   logic [NUM_DST-1:0]          wr_done;
   logic [NUM_DST*SRC_W-1:0]    wr_done_src;
   logic [NUM_DST-1:0]          wlast_err;

   modport slave (
      input  aw_push, aw_src, aw_dst, aw_len,
      output aw_full,
      input  S_AXI_wdata, S_AXI_wstrb, S_AXI_wlast, S_AXI_wvalid,
      output S_AXI_wready,
      output M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast, M_AXI_wvalid,
      input  M_AXI_wready,
      output wr_done, wr_done_src, wlast_err
   );

   modport master (
      output aw_push, aw_src, aw_dst, aw_len,
      input  aw_full,
      output S_AXI_wdata, S_AXI_wstrb, S_AXI_wlast, S_AXI_wvalid,
      input  S_AXI_wready,
      input  M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast, M_AXI_wvalid,
      output M_AXI_wready,
      input  wr_done, wr_done_src, wlast_err
   );

endinterface

`default_nettype wire

// File: rtl/wd_order_fifo.sv
// ============================================================================
// Module : wd_order_fifo
// Brief  : Small synchronous FIFO holding AW ordering entries; head is dout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wd_order_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             push,
   input  wire logic             pop,
   input  wire logic [WIDTH-1:0] din,
   output logic      [WIDTH-1:0] dout,
   output logic                  empty,
   output logic                  full
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   // Full is taken from the registered count, so a same-cycle pop never admits a push.
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/wd_xbar_router.sv
// ============================================================================
// Module : wd_xbar_router
// Brief  : AXI W-channel crossbar router steered by AW grant order, with WLAST generation.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wd_xbar_router
   import wd_xbar_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int NUM_DST = 2,
   parameter int DATA_W  = 32,
   parameter int QDEPTH  = 4
) (
   input  wire logic       ACLK,
   input  wire logic       ARESETN,
   wd_xbar_router_if.slave bus
);
   localparam int SRC_W  = id_width(NUM_SRC);
   localparam int DST_W  = id_width(NUM_DST);
   localparam int STRB_W = DATA_W / 8;
   localparam int DQ_W   = SRC_W + LEN_W;

   logic [NUM_DST-1:0] dq_push, dq_pop, dq_empty, dq_full;
   logic [DQ_W-1:0]    dq_head [NUM_DST];
   logic [NUM_SRC-1:0] sq_push, sq_pop, sq_empty, sq_full;
   logic [DST_W-1:0]   sq_head [NUM_SRC];

   logic [LEN_W-1:0]   beat_cnt  [NUM_DST];
   logic [NUM_DST-1:0] route_active;
   logic [SRC_W-1:0]   route_src [NUM_DST];
   logic [NUM_SRC-1:0] src_active;
   logic [DST_W-1:0]   src_dst   [NUM_SRC];

   logic                     aw_full;
   logic                     aw_accept;
   logic [NUM_DST-1:0]       hs;
   logic [NUM_DST-1:0]       last_hs;
   logic [NUM_DST-1:0]       m_wvalid, m_wlast, wlast_err;
   logic [NUM_DST*DATA_W-1:0] m_wdata;
   logic [NUM_DST*STRB_W-1:0] m_wstrb;
   logic [NUM_DST*SRC_W-1:0]  done_src;
   logic [NUM_SRC-1:0]       s_wready;

   always_comb begin
      aw_full = 1'b0;
      for (int d = 0; d < NUM_DST; d++)
         if (bus.aw_dst == DST_W'(d)) aw_full = aw_full | dq_full[d];
      for (int s = 0; s < NUM_SRC; s++)
         if (bus.aw_src == SRC_W'(s)) aw_full = aw_full | sq_full[s];
   end

   assign aw_accept = bus.aw_push & ~aw_full;

   always_comb begin
      dq_push = '0;
      sq_push = '0;
      for (int d = 0; d < NUM_DST; d++)
         dq_push[d] = aw_accept & (bus.aw_dst == DST_W'(d));
      for (int s = 0; s < NUM_SRC; s++)
         sq_push[s] = aw_accept & (bus.aw_src == SRC_W'(s));
   end

   generate
      for (genvar d = 0; d < NUM_DST; d++) begin : g_dq
         wd_order_fifo #(.WIDTH(DQ_W), .DEPTH(QDEPTH)) u_dq (
            .clk   (ACLK),
            .rst_n (ARESETN),
            .push  (dq_push[d]),
            .pop   (dq_pop[d]),
            .din   ({bus.aw_src, bus.aw_len}),
            .dout  (dq_head[d]),
            .empty (dq_empty[d]),
            .full  (dq_full[d])
         );
      end
      for (genvar s = 0; s < NUM_SRC; s++) begin : g_sq
         wd_order_fifo #(.WIDTH(DST_W), .DEPTH(QDEPTH)) u_sq (
            .clk   (ACLK),
            .rst_n (ARESETN),
            .push  (sq_push[s]),
            .pop   (sq_pop[s]),
            .din   (bus.aw_dst),
            .dout  (sq_head[s]),
            .empty (sq_empty[s]),
            .full  (sq_full[s])
         );
      end
   endgenerate

   // A route exists only when both order queues agree on the pairing at their heads.
   always_comb begin
      route_active = '0;
      src_active   = '0;
      for (int d = 0; d < NUM_DST; d++) route_src[d] = '0;
      for (int s = 0; s < NUM_SRC; s++) src_dst[s] = '0;
      for (int d = 0; d < NUM_DST; d++) begin
         for (int s = 0; s < NUM_SRC; s++) begin
            if (!dq_empty[d] && !sq_empty[s] &&
                dq_head[d][ENTRY_SRC_LSB +: SRC_W] == SRC_W'(s) &&
                sq_head[s] == DST_W'(d)) begin
               route_active[d] = 1'b1;
               route_src[d]    = SRC_W'(s);
               src_active[s]   = 1'b1;
               src_dst[s]      = DST_W'(d);
            end
         end
      end
   end

   always_comb begin
      m_wvalid  = '0;
      m_wlast   = '0;
      m_wdata   = '0;
      m_wstrb   = '0;
      done_src  = '0;
      wlast_err = '0;
      hs        = '0;
      last_hs   = '0;
      s_wready  = '0;
      sq_pop    = '0;
      for (int d = 0; d < NUM_DST; d++) begin
         if (route_active[d]) begin
            m_wvalid[d] = bus.S_AXI_wvalid[route_src[d]];
            m_wlast[d]  = (beat_cnt[d] == dq_head[d][ENTRY_LEN_LSB +: LEN_W]);
            m_wdata[d*DATA_W +: DATA_W] = bus.S_AXI_wdata[route_src[d]*DATA_W +: DATA_W];
            m_wstrb[d*STRB_W +: STRB_W] = bus.S_AXI_wstrb[route_src[d]*STRB_W +: STRB_W];
            done_src[d*SRC_W +: SRC_W]  = route_src[d];
            hs[d]        = m_wvalid[d] & bus.M_AXI_wready[d];
            last_hs[d]   = hs[d] & m_wlast[d];
            wlast_err[d] = hs[d] & (bus.S_AXI_wlast[route_src[d]] != m_wlast[d]);
         end
      end
      for (int s = 0; s < NUM_SRC; s++) begin
         if (src_active[s]) begin
            s_wready[s] = bus.M_AXI_wready[src_dst[s]];
            sq_pop[s]   = last_hs[src_dst[s]];
         end
      end
   end

   assign dq_pop = last_hs;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int d = 0; d < NUM_DST; d++) beat_cnt[d] <= '0;
      end else begin
         for (int d = 0; d < NUM_DST; d++) begin
            if (last_hs[d])
               beat_cnt[d] <= '0;
            else if (hs[d])
               beat_cnt[d] <= beat_cnt[d] + LEN_W'(1);
         end
      end
   end

   assign bus.aw_full      = aw_full;
   assign bus.S_AXI_wready = s_wready;
   assign bus.M_AXI_wdata  = m_wdata;
   assign bus.M_AXI_wstrb  = m_wstrb;
   assign bus.M_AXI_wlast  = m_wlast;
   assign bus.M_AXI_wvalid = m_wvalid;
   assign bus.wr_done      = last_hs;
   assign bus.wr_done_src  = done_src;
   assign bus.wlast_err    = wlast_err;

endmodule

`default_nettype wire

// File: tb/tb_wd_xbar_router.sv
// ============================================================================
// Module : tb_wd_xbar_router
// Brief  : Directed and random stimulus for wd_xbar_router against a queue-based model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wd_xbar_router;
   import wd_xbar_pkg::*;

   localparam int NUM_SRC = 2;
   localparam int NUM_DST = 2;
   localparam int DATA_W  = 32;
   localparam int QDEPTH  = 4;
   localparam int SRC_W   = id_width(NUM_SRC);
   localparam int STRB_W  = DATA_W / 8;

   logic clk;
   logic rstn;
   int   checks = 0;
   int   errors = 0;

   // Reference model: order queues as plain SV queues, beat counts per destination.
   int mdq_src [NUM_DST][$];
   int mdq_len [NUM_DST][$];
   int msq     [NUM_SRC][$];
   int mcnt    [NUM_DST];

   wd_xbar_router_if #(.NUM_SRC(NUM_SRC), .NUM_DST(NUM_DST), .DATA_W(DATA_W)) bus ();

   wd_xbar_router #(
      .NUM_SRC (NUM_SRC),
      .NUM_DST (NUM_DST),
      .DATA_W  (DATA_W),
      .QDEPTH  (QDEPTH)
   ) dut (
      .ACLK    (clk),
      .ARESETN (rstn),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_empty();
      for (int d = 0; d < NUM_DST; d++) if (mdq_src[d].size() != 0) return 1'b0;
      for (int s = 0; s < NUM_SRC; s++) if (msq[s].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_clear();
      for (int d = 0; d < NUM_DST; d++) begin
         mdq_src[d].delete();
         mdq_len[d].delete();
         mcnt[d] = 0;
      end
      for (int s = 0; s < NUM_SRC; s++) msq[s].delete();
   endtask

   // Compare every output against the model mid-cycle, then advance the model at the edge.
   task automatic cycle();
      logic [NUM_DST-1:0]        ev, el, ed, ee, hs;
      logic [NUM_SRC-1:0]        er;
      logic [NUM_DST*DATA_W-1:0] edat;
      logic [NUM_DST*STRB_W-1:0] estb;
      logic [NUM_DST*SRC_W-1:0]  esrc;
      int rs [NUM_DST];
      bit efull;
      bit pu;
      int ps, pd, pl;
      #3;
      ev = '0; el = '0; ed = '0; ee = '0; hs = '0; er = '0;
      edat = '0; estb = '0; esrc = '0;
      for (int d = 0; d < NUM_DST; d++) begin
         rs[d] = -1;
         if (mdq_src[d].size() > 0) begin
            int s;
            s = mdq_src[d][0];
            if (msq[s].size() > 0 && msq[s][0] == d) begin
               rs[d] = s;
               ev[d] = bus.S_AXI_wvalid[s];
               el[d] = (mcnt[d] == mdq_len[d][0]);
               edat[d*DATA_W +: DATA_W] = bus.S_AXI_wdata[s*DATA_W +: DATA_W];
               estb[d*STRB_W +: STRB_W] = bus.S_AXI_wstrb[s*STRB_W +: STRB_W];
               esrc[d*SRC_W +: SRC_W]   = SRC_W'(s);
               er[s] = bus.M_AXI_wready[d];
               hs[d] = ev[d] & bus.M_AXI_wready[d];
               ed[d] = hs[d] & el[d];
               ee[d] = hs[d] & (bus.S_AXI_wlast[s] != el[d]);
            end
         end
      end
      pu = bus.aw_push;
      ps = int'(bus.aw_src);
      pd = int'(bus.aw_dst);
      pl = int'(bus.aw_len);
      efull = (mdq_src[pd].size() >= QDEPTH) || (msq[ps].size() >= QDEPTH);
      check("aw_full",     64'(bus.aw_full),      64'(efull));
      check("m_wvalid",    64'(bus.M_AXI_wvalid), 64'(ev));
      check("m_wlast",     64'(bus.M_AXI_wlast),  64'(el));
      check("m_wdata",     64'(bus.M_AXI_wdata),  64'(edat));
      check("m_wstrb",     64'(bus.M_AXI_wstrb),  64'(estb));
      check("s_wready",    64'(bus.S_AXI_wready), 64'(er));
      check("wr_done",     64'(bus.wr_done),      64'(ed));
      check("wr_done_src", 64'(bus.wr_done_src),  64'(esrc));
      check("wlast_err",   64'(bus.wlast_err),    64'(ee));
      @(posedge clk);
      for (int d = 0; d < NUM_DST; d++) begin
         if (hs[d]) begin
            if (el[d]) begin
               void'(mdq_src[d].pop_front());
               void'(mdq_len[d].pop_front());
               void'(msq[rs[d]].pop_front());
               mcnt[d] = 0;
            end else begin
               mcnt[d]++;
            end
         end
      end
      if (pu && !efull) begin
         mdq_src[pd].push_back(ps);
         mdq_len[pd].push_back(pl);
         msq[ps].push_back(pd);
      end
      #1;
   endtask

   task automatic push_aw(input int src, input int dst, input int len);
      bus.aw_src  = 1'(src);
      bus.aw_dst  = 1'(dst);
      bus.aw_len  = 8'(len);
      bus.aw_push = 1'b1;
      cycle();
      bus.aw_push = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.aw_push      = 1'b0;
      bus.S_AXI_wvalid = '1;
      bus.M_AXI_wready = '1;
      while (!model_empty() && n < 300) begin
         bus.S_AXI_wdata = {$urandom, $urandom};
         bus.S_AXI_wstrb = 8'($urandom);
         bus.S_AXI_wlast = 2'($urandom);
         cycle();
         n++;
      end
      check("drain_bound", 64'(n < 300), 64'(1));
      bus.S_AXI_wvalid = '0;
      bus.M_AXI_wready = '0;
   endtask

   initial begin
      model_clear();
      rstn             = 1'b0;
      bus.aw_push      = 1'b0;
      bus.aw_src       = '0;
      bus.aw_dst       = '0;
      bus.aw_len       = '0;
      bus.S_AXI_wdata  = 64'h1234_5678_9abc_def0;
      bus.S_AXI_wstrb  = 8'hff;
      bus.S_AXI_wlast  = '1;
      bus.S_AXI_wvalid = '1;
      bus.M_AXI_wready = '1;

      // Reset values, with live handshake inputs present.
      repeat (2) @(posedge clk);
      #1;
      check("rst_m_wvalid",  64'(bus.M_AXI_wvalid), 64'(0));
      check("rst_s_wready",  64'(bus.S_AXI_wready), 64'(0));
      check("rst_m_wlast",   64'(bus.M_AXI_wlast),  64'(0));
      check("rst_m_wdata",   64'(bus.M_AXI_wdata),  64'(0));
      check("rst_wr_done",   64'(bus.wr_done),      64'(0));
      check("rst_done_src",  64'(bus.wr_done_src),  64'(0));
      check("rst_wlast_err", 64'(bus.wlast_err),    64'(0));
      check("rst_aw_full",   64'(bus.aw_full),      64'(0));
      bus.S_AXI_wvalid = '0;
      bus.M_AXI_wready = '0;
      bus.S_AXI_wlast  = '0;
      rstn = 1'b1;
      cycle();

      // Single burst src1 -> dst0, four beats.
      push_aw(1, 0, 3);
      bus.S_AXI_wvalid = 2'b10;
      bus.M_AXI_wready = 2'b01;
      for (int i = 0; i < 4; i++) begin
         bus.S_AXI_wdata = {$urandom, $urandom};
         bus.S_AXI_wstrb = 8'($urandom);
         bus.S_AXI_wlast = (i == 3) ? 2'b10 : 2'b00;
         #1;
         check("single_s0_ready", 64'(bus.S_AXI_wready[0]), 64'(0));
         if (i == 3) begin
            check("single_done",     64'(bus.wr_done[0]),     64'(1));
            check("single_done_src", 64'(bus.wr_done_src[0]), 64'(1));
         end
         cycle();
      end
      bus.S_AXI_wvalid = '0;
      bus.M_AXI_wready = '0;
      cycle();

      // Parallel routes src0->dst1 (2 beats) and src1->dst0 (3 beats).
      push_aw(0, 1, 1);
      push_aw(1, 0, 2);
      bus.S_AXI_wvalid = 2'b11;
      bus.M_AXI_wready = 2'b11;
      for (int i = 0; i < 3; i++) begin
         bus.S_AXI_wdata = {$urandom, $urandom};
         bus.S_AXI_wstrb = 8'($urandom);
         bus.S_AXI_wlast = {1'(i == 2), 1'(i == 1)};
         #1;
         if (i == 1) check("par_done_d1", 64'(bus.wr_done), 64'(2'b10));
         if (i == 2) check("par_done_d0", 64'(bus.wr_done), 64'(2'b01));
         cycle();
      end
      bus.S_AXI_wvalid = '0;
      bus.M_AXI_wready = '0;

      // Per-source ordering: src0 to dst0 then dst1, with only dst1 ready.
      push_aw(0, 0, 0);
      push_aw(0, 1, 0);
      bus.S_AXI_wvalid = 2'b01;
      bus.S_AXI_wlast  = 2'b01;
      bus.M_AXI_wready = 2'b10;
      cycle();
      cycle();
      #1;
      check("order_s0_ready", 64'(bus.S_AXI_wready[0]), 64'(0));
      check("order_d1_valid", 64'(bus.M_AXI_wvalid[1]), 64'(0));
      bus.M_AXI_wready = 2'b11;
      cycle();
      cycle();
      bus.S_AXI_wvalid = '0;
      bus.M_AXI_wready = '0;
      cycle();

      // Queue full: four bursts into dst0, a fifth is dropped.
      for (int i = 0; i < 4; i++) push_aw(1, 0, 0);
      #1;
      check("full_after_4", 64'(bus.aw_full), 64'(1));
      push_aw(1, 0, 0);
      bus.S_AXI_wvalid = 2'b10;
      bus.S_AXI_wlast  = 2'b10;
      bus.M_AXI_wready = 2'b01;
      #1;
      check("full_during_pop", 64'(bus.aw_full), 64'(1));
      cycle();
      bus.S_AXI_wvalid = '0;
      #1;
      check("full_after_pop", 64'(bus.aw_full), 64'(0));
      drain();
      check("full_fifth_dropped", 64'(checks > 0 && model_empty()), 64'(1));

      // Source WLAST early on a three-beat burst.
      push_aw(0, 0, 2);
      bus.S_AXI_wvalid = 2'b01;
      bus.M_AXI_wready = 2'b01;
      for (int i = 0; i < 3; i++) begin
         bus.S_AXI_wlast = {1'b0, 1'(i == 1)};
         #1;
         check("wlerr_pulse", 64'(bus.wlast_err[0]), 64'(i >= 1));
         check("wlerr_done",  64'(bus.wr_done[0]),   64'(i == 2));
         cycle();
      end
      bus.S_AXI_wvalid = '0;
      bus.M_AXI_wready = '0;

      // Reset in the middle of a four-beat burst.
      push_aw(1, 1, 3);
      bus.S_AXI_wvalid = 2'b10;
      bus.S_AXI_wlast  = 2'b00;
      bus.M_AXI_wready = 2'b10;
      cycle();
      cycle();
      rstn = 1'b0;
      #1;
      check("midrst_m_wvalid", 64'(bus.M_AXI_wvalid), 64'(0));
      check("midrst_s_wready", 64'(bus.S_AXI_wready), 64'(0));
      check("midrst_m_wdata",  64'(bus.M_AXI_wdata),  64'(0));
      model_clear();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      bus.S_AXI_wlast = 2'b10;
      push_aw(1, 1, 0);
      #1;
      check("post_rst_wlast", 64'(bus.M_AXI_wlast[1]), 64'(1));
      check("post_rst_done",  64'(bus.wr_done[1]),     64'(1));
      cycle();
      bus.S_AXI_wvalid = '0;
      bus.M_AXI_wready = '0;

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         bus.aw_push      = ($urandom_range(0, 3) == 0);
         bus.aw_src       = 1'($urandom);
         bus.aw_dst       = 1'($urandom);
         bus.aw_len       = 8'($urandom_range(0, 3));
         bus.S_AXI_wdata  = {$urandom, $urandom};
         bus.S_AXI_wstrb  = 8'($urandom);
         bus.S_AXI_wlast  = 2'($urandom);
         bus.S_AXI_wvalid = 2'($urandom);
         bus.M_AXI_wready = 2'($urandom);
         cycle();
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/wd_xbar_router.md
Name: wd_xbar_router

Overview:
- Parametrised write-data (W) channel router for the AXI interconnect. Connects NUM_SRC upstream slave ports to NUM_DST downstream master ports.
- Routing is driven by AW-channel grants. Each grant pushes the granted source ID and burst length into a per-destination order queue. The same grant pushes the destination ID into a per-source order queue, which preserves AXI per-master W ordering.
- The block generates the downstream WLAST from a beat counter, replacing the per-port virtual-master last logic. It reports burst completion and the owning source to the B channel.

Parameters:
- NUM_SRC, 2, number of upstream (S) ports.
- NUM_DST, 2, number of downstream (M) ports.
- DATA_W, 32, W data width in bits; STRB_W = DATA_W/8 is derived.
- QDEPTH, 4, entries per order queue; must be a power of 2 and at least 2.
- SRC_W, $clog2(NUM_SRC) with a minimum of 1, width of a source ID.
- DST_W, $clog2(NUM_DST) with a minimum of 1, width of a destination ID.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- aw_push  in  1  AW grant accepted this cycle.
- aw_src  in  SRC_W  granted source port.
- aw_dst  in  DST_W  decoded destination port.
- aw_len  in  8  AXI AWLEN; the burst has aw_len+1 beats.
- aw_full  out  1  push would be rejected; combinational from aw_src/aw_dst.
- S_AXI_wdata  in  NUM_SRC*DATA_W  flattened source data.
- S_AXI_wstrb  in  NUM_SRC*STRB_W  source strobes.
- S_AXI_wlast  in  NUM_SRC  source last flags, checked only.
- S_AXI_wvalid  in  NUM_SRC  source valid.
- S_AXI_wready  out  NUM_SRC  source ready.
- M_AXI_wdata  out  NUM_DST*DATA_W  destination data.
- M_AXI_wstrb  out  NUM_DST*STRB_W  destination strobes.
- M_AXI_wlast  out  NUM_DST  generated last.
- M_AXI_wvalid  out  NUM_DST  destination valid.
- M_AXI_wready  in  NUM_DST  destination ready.
- wr_done  out  NUM_DST  1-cycle pulse when the last beat handshakes at that destination.
- wr_done_src  out  NUM_DST*SRC_W  source ID of the completed burst, valid while wr_done is high.
- wlast_err  out  NUM_DST  1-cycle pulse when source WLAST disagrees with the generated last.

Behaviour:
- Reset (async, ARESETN=0):
  - All queues are emptied and all beat counters are set to 0.
  - M_AXI_wvalid, S_AXI_wready, wr_done and wlast_err are 0.
  - M_AXI_wlast and aw_full are 0.
  - M_AXI_wdata, M_AXI_wstrb and wr_done_src are 0, because the mux output is forced to 0 when no route is active.
- Queue push:
  - aw_full = dq_full[aw_dst] | sq_full[aw_src], computed from registered counts.
  - A push while full is ignored. The same-cycle pop does not free a slot for the push.
  - An accepted push writes {aw_src, aw_len} into dst queue aw_dst and aw_dst into src queue aw_src.
  - The entry becomes visible at the queue head on the next cycle.
- Route active (destination d, source s):
  - Condition: dq[d] is non-empty, its head src is s, sq[s] is non-empty, and its head dst is d.
  - At most one d can match any s.
- Datapath while d is routed to s (purely combinational):
  - M_AXI_wvalid[d] = S_AXI_wvalid[s].
  - S_AXI_wready[s] = M_AXI_wready[d].
  - M_AXI_wdata and M_AXI_wstrb come from source s.
- When no route is active: M valid is 0, S ready is 0, and the data mux outputs 0. Zero cycles of latency are added to the data path.
- Beat counter (per destination):
  - Increments on each handshake (valid & ready).
  - M_AXI_wlast[d] = route_active & (beat_cnt[d] == head_len).
- Last handshake:
  - Pops dq[d] and sq[s], resets beat_cnt[d] to 0, and pulses wr_done[d] with wr_done_src = s.
  - The next queued burst may handshake from the following cycle; there is one cycle between bursts.
- WLAST check:
  - On each handshake, if S_AXI_wlast[s] != M_AXI_wlast[d], pulse wlast_err[d] in the same cycle.
  - Routing follows the counter only; a wrong source WLAST never ends a burst early or late.
- Blocking:
  - If the head of source s's queue is destination e and dq[e] is headed by a different source, s is blocked. This is legal AXI ordering; no deadlock avoidance is attempted beyond the AW arbiter.
- Simultaneous push and pop on the same queue: both take effect, and the count is unchanged.
- Pointer wrap: pointers are modulo QDEPTH; count is tracked in $clog2(QDEPTH)+1 bits.
- Reset mid-burst: the burst is discarded, and outputs return to their reset values asynchronously.

Decomposition:
- Package wd_xbar_pkg holds the width helpers (SRC_W, DST_W, LEN_W=8) and an entry layout constant for packing {src, len}.
- One sub-module, wd_order_fifo, a parametrised synchronous FIFO:
  - Parameters: width, depth.
  - Ports: push, pop, din, dout (head), empty, full; async active-low reset.
- The top level instantiates NUM_DST destination FIFOs (width SRC_W+8) and NUM_SRC source FIFOs (width DST_W), plus generate-loop muxes and counters.

Test Plan:
- Single burst: push src=1, dst=0, len=3; S01 streams 4 beats with wready=1 → M00 sees 4 beats, wlast on beat 4 only, wr_done[0]=1 with wr_done_src=1, S00 wready stays 0.
- Parallel routes: src0→dst1 (len=1) and src1→dst0 (len=2) pushed on consecutive cycles → both transfer concurrently with no cross-talk; wr_done[1] after 2 beats, wr_done[0] after 3.
- Ordering: src0 pushes dst0 (len=0) then dst1 (len=0), and dst1 is ready first → no wready to src0 at dst1 until the dst0 beat completes.
- Backpressure and full: with QDEPTH=4, push 4 bursts to dst0 → aw_full=1 for dst0; a 5th push is ignored; aw_full deasserts the cycle after the first pop.
- WLAST mismatch: len=2, source asserts wlast on beat 2 → wlast_err pulses on beat 2 and on beat 3; the burst still ends on beat 3.
- Reset mid-burst: deassert ARESETN after 2 of 4 beats → all valid/ready drop immediately; after release, a new push len=0 completes normally with no residual count.
